// File: rtl/seg_scan_driver.sv
// Time-multiplexed four-digit common-anode 7-segment driver with per-slot
// dead-time blanking and once-per-frame capture of digits and blank mask.
module seg_scan_driver #(
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit_a,
  input  logic [3:0] digit_b,
  input  logic [3:0] digit_c,
  input  logic [3:0] digit_d,
  input  logic [3:0] blank_mask,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_start
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0][3:0]  digits_q, digits_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             frame_start_q, frame_start_d;
  logic             cnt_last_c;
  logic             load_c;
  logic [3:0]       nibble_c;

  // Active-low gfedcba pattern for a hex nibble.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BLANK;
      cnt_q         <= '0;
      idx_q         <= '0;
      digits_q      <= '0;
      mask_q        <= '0;
      an_q          <= 4'b1111;
      seg_q         <= 7'b1111111;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      digits_q      <= digits_d;
      mask_q        <= mask_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_last_c    = (cnt_q == CNT_LAST);
    load_c        = (idx_q == 2'd0) && (cnt_q == '0);
    cnt_d         = cnt_last_c ? '0 : cnt_q + CNT_W'(1);
    idx_d         = cnt_last_c ? idx_q + 2'd1 : idx_q;
    digits_d      = load_c ? {digit_d, digit_c, digit_b, digit_a} : digits_q;
    mask_d        = load_c ? blank_mask : mask_q;
    nibble_c      = digits_q[idx_q];
    an_d          = 4'b1111;
    seg_d         = 7'b1111111;
    frame_start_d = load_c;

    // State tracks cnt_q so the output decode below sees the current slot phase.
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) state_d = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (cnt_last_c) state_d = ST_BLANK;
        if (!mask_q[2'd3 - idx_q]) begin
          an_d  = ~(4'b1000 >> idx_q);
          seg_d = hex_decode(nibble_c);
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two parameterisations checked every cycle against
// an arithmetic model of slot/frame timing, plus literal spot checks.
module tb_seg_scan_driver;

  logic       clk;
  logic       rst_n;
  logic [3:0] digit_a, digit_b, digit_c, digit_d, blank_mask;
  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       fs_a, fs_b;

  int total = 0;
  int bad   = 0;
  int last_k = -1;

  logic [6:0] dec [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  seg_scan_driver #(.TICK_DIV(8), .BLANK_CYCLES(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .digit_a(digit_a), .digit_b(digit_b),
    .digit_c(digit_c), .digit_d(digit_d), .blank_mask(blank_mask),
    .an(an_a), .seg(seg_a), .frame_start(fs_a));

  seg_scan_driver #(.TICK_DIV(5), .BLANK_CYCLES(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .digit_a(digit_a), .digit_b(digit_b),
    .digit_c(digit_c), .digit_d(digit_d), .blank_mask(blank_mask),
    .an(an_b), .seg(seg_b), .frame_start(fs_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b t=%0t", name, got, want, $time);
    end
  endtask

  // Reference model: slot position is pure arithmetic on the edge count since release.
  int         tdv [2] = '{8, 5};
  int         bdc [2] = '{2, 1};
  logic [3:0] sh_dig [2][4];
  logic [3:0] sh_msk [2];

  always @(posedge clk) begin
    logic [3:0] exp_an [2];
    logic [6:0] exp_seg [2];
    logic       exp_fs [2];
    logic [3:0] in_dig [4];
    int k;
    if (!rst_n) begin
      last_k = -1;
      #1;
      chk("rst_an_a", 7'(an_a), 7'(4'b1111));
      chk("rst_seg_a", seg_a, 7'h7F);
      chk("rst_fs_a", 7'(fs_a), 7'd0);
      chk("rst_an_b", 7'(an_b), 7'(4'b1111));
      chk("rst_fs_b", 7'(fs_b), 7'd0);
    end else begin
      k = last_k + 1;
      in_dig = '{digit_a, digit_b, digit_c, digit_d};
      for (int i = 0; i < 2; i++) begin
        int cnt, idx;
        cnt = k % tdv[i];
        idx = (k / tdv[i]) % 4;
        exp_fs[i] = (cnt == 0 && idx == 0);
        if (exp_fs[i]) begin
          for (int j = 0; j < 4; j++) sh_dig[i][j] = in_dig[j];
          sh_msk[i] = blank_mask;
        end
        if (cnt < bdc[i] || sh_msk[i][3 - idx]) begin
          exp_an[i]  = 4'b1111;
          exp_seg[i] = 7'h7F;
        end else begin
          exp_an[i]  = 4'b1111;
          exp_an[i][3 - idx] = 1'b0;
          exp_seg[i] = dec[sh_dig[i][idx]];
        end
      end
      #1;
      chk("model_an_a", 7'(an_a), 7'(exp_an[0]));
      chk("model_seg_a", seg_a, exp_seg[0]);
      chk("model_fs_a", 7'(fs_a), 7'(exp_fs[0]));
      chk("model_an_b", 7'(an_b), 7'(exp_an[1]));
      chk("model_seg_b", seg_b, exp_seg[1]);
      chk("model_fs_b", 7'(fs_b), 7'(exp_fs[1]));
      chk("onehot_an_a", 7'($countones(~an_a) <= 1), 7'd1);
      chk("onehot_an_b", 7'($countones(~an_b) <= 1), 7'd1);
      last_k = k;
    end
  end

  // Advance to the negedge after the edge whose index mod 32 equals m (instance A frame).
  task automatic wait_k(input int m);
    int n;
    n = 0;
    @(negedge clk);
    while ((last_k < 0 || (last_k % 32) != m) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_k_timeout", 7'(n < 200), 7'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    digit_a = 4'h1; digit_b = 4'h2; digit_c = 4'h3; digit_d = 4'h4;
    blank_mask = 4'b0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Scan order, blanking and frame pulse pinned with literals.
    @(posedge clk); #2;
    chk("pin_fs_first", 7'(fs_a), 7'd1);
    chk("pin_blank_first", 7'(an_a), 7'(4'b1111));
    repeat (2) @(posedge clk); #2;
    chk("pin_an_d1", 7'(an_a), 7'(4'b0111));
    chk("pin_seg_d1", seg_a, 7'b1111001);
    repeat (8) @(posedge clk); #2;
    chk("pin_an_d2", 7'(an_a), 7'(4'b1011));
    chk("pin_seg_d2", seg_a, 7'b0100100);
    repeat (8) @(posedge clk); #2;
    chk("pin_an_d3", 7'(an_a), 7'(4'b1101));
    chk("pin_seg_d3", seg_a, 7'b0110000);
    repeat (8) @(posedge clk); #2;
    chk("pin_an_d4", 7'(an_a), 7'(4'b1110));
    chk("pin_seg_d4", seg_a, 7'b0011001);
    chk("pin_fs_low", 7'(fs_a), 7'd0);
    repeat (6) @(posedge clk); #2;
    chk("pin_fs_32", 7'(fs_a), 7'd1);

    // Every hex code through digit_a, one per frame.
    for (int v = 0; v < 16; v++) begin
      wait_k(8);
      digit_a = 4'(v);
      wait_k(4);
      chk("hex_code", seg_a, dec[v]);
    end

    // Mid-frame change only shows from the next frame.
    digit_c = 4'h3;
    wait_k(10);
    digit_c = 4'h9;
    wait_k(20);
    chk("tear_same_frame", seg_a, 7'b0110000);
    wait_k(20);
    chk("tear_next_frame", seg_a, 7'b0010000);

    // Blank mask.
    digit_a = 4'hA; digit_b = 4'hB; digit_c = 4'hC; digit_d = 4'hD;
    blank_mask = 4'b0101;
    wait_k(0);
    wait_k(4);
    chk("mask_an3", 7'(an_a), 7'(4'b0111));
    chk("mask_seg3", seg_a, 7'b0001000);
    wait_k(12);
    chk("mask_an2", 7'(an_a), 7'(4'b1111));
    chk("mask_seg2", seg_a, 7'h7F);
    wait_k(20);
    chk("mask_an1", 7'(an_a), 7'(4'b1101));
    chk("mask_seg1", seg_a, 7'b1000110);
    wait_k(28);
    chk("mask_an0", 7'(an_a), 7'(4'b1111));
    blank_mask = 4'b0000;

    // Asynchronous reset in the middle of the an[1] drive window.
    wait_k(20);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", 7'(an_a), 7'(4'b1111));
    chk("async_seg", seg_a, 7'h7F);
    chk("async_fs", 7'(fs_a), 7'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("post_rst_fs", 7'(fs_a), 7'd1);
    repeat (2) @(posedge clk); #2;
    chk("post_rst_an", 7'(an_a), 7'(4'b0111));

    // Random inputs; the per-cycle model covers correctness.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) digit_a = 4'($urandom);
      if ($urandom_range(7) == 0) digit_b = 4'($urandom);
      if ($urandom_range(7) == 0) digit_c = 4'($urandom);
      if ($urandom_range(7) == 0) digit_d = 4'($urandom);
      if ($urandom_range(15) == 0) blank_mask = 4'($urandom);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
